// File: rtl/impulsos_multicanal.sv
// Multi-channel impulse generator: turns debounced button levels into one-cycle
// impulses (rising/falling edge or auto-repeat) and counts them with saturation.
module impulsos_multicanal #(
   parameter int N_CANALES    = 4,
   parameter int RETARDO_REP  = 500,
   parameter int PERIODO_REP  = 100,
   parameter int ANCHO_CUENTA = 8
) (
   input  logic                    clock1k,
   input  logic                    reset,
   input  logic [N_CANALES-1:0]    botonesLimpios,
   input  logic [1:0]              modo,
   input  logic                    habilitar,
   output logic [N_CANALES-1:0]    impulsos,
   output logic [ANCHO_CUENTA-1:0] numImpulsos,
   output logic [N_CANALES-1:0]    repitiendo
);

   localparam int MAX_CUENTA = (RETARDO_REP > PERIODO_REP) ? RETARDO_REP : PERIODO_REP;
   localparam int ANCHO_CNT  = $clog2(MAX_CUENTA);
   localparam int ANCHO_POP  = $clog2(N_CANALES + 1);
   localparam int ANCHO_SUMA = ((ANCHO_CUENTA > ANCHO_POP) ? ANCHO_CUENTA : ANCHO_POP) + 1;

   localparam logic [ANCHO_CNT-1:0]  CARGA_RETARDO = ANCHO_CNT'(RETARDO_REP - 1);
   localparam logic [ANCHO_CNT-1:0]  CARGA_PERIODO = ANCHO_CNT'(PERIODO_REP - 1);
   localparam logic [ANCHO_CNT-1:0]  UNO           = ANCHO_CNT'(1);
   localparam logic [ANCHO_SUMA-1:0] TOPE          = ANCHO_SUMA'({ANCHO_CUENTA{1'b1}});

   localparam logic [1:0] MODO_SUBIDA = 2'b01;
   localparam logic [1:0] MODO_BAJADA = 2'b10;
   localparam logic [1:0] MODO_REPITE = 2'b11;

   typedef enum logic [1:0] {
      REPOSO = 2'd0,
      ESPERA = 2'd1,
      REPITE = 2'd2
   } estado_t;

   logic [N_CANALES-1:0]    previo_q;
   logic [N_CANALES-1:0]    subida;
   logic [N_CANALES-1:0]    bajada;
   estado_t                 estado_q [N_CANALES];
   estado_t                 estado_d [N_CANALES];
   logic [ANCHO_CNT-1:0]    cuenta_q [N_CANALES];
   logic [ANCHO_CNT-1:0]    cuenta_d [N_CANALES];
   logic [N_CANALES-1:0]    impulsos_q;
   logic [N_CANALES-1:0]    impulsos_d;
   logic [N_CANALES-1:0]    repitiendo_q;
   logic [N_CANALES-1:0]    repitiendo_d;
   logic [ANCHO_CUENTA-1:0] numImpulsos_q;
   logic [ANCHO_CUENTA-1:0] numImpulsos_d;
   logic [ANCHO_POP-1:0]    popcount;
   logic [ANCHO_SUMA-1:0]   suma;

   // Per-channel next state: any mode other than auto-repeat, or a disabled
   // generator, leaves the channel idle with a cleared counter.
   always_comb begin
      subida = botonesLimpios & ~previo_q;
      bajada = ~botonesLimpios & previo_q;
      for (int i = 0; i < N_CANALES; i++) begin
         estado_d[i]   = REPOSO;
         cuenta_d[i]   = '0;
         impulsos_d[i] = 1'b0;
         if (habilitar) begin
            case (modo)
               MODO_SUBIDA: impulsos_d[i] = subida[i];
               MODO_BAJADA: impulsos_d[i] = bajada[i];
               MODO_REPITE: begin
                  case (estado_q[i])
                     REPOSO: begin
                        if (subida[i]) begin
                           impulsos_d[i] = 1'b1;
                           estado_d[i]   = ESPERA;
                           cuenta_d[i]   = CARGA_RETARDO;
                        end
                     end
                     ESPERA: begin
                        if (botonesLimpios[i]) begin
                           if (cuenta_q[i] == '0) begin
                              impulsos_d[i] = 1'b1;
                              estado_d[i]   = REPITE;
                              cuenta_d[i]   = CARGA_PERIODO;
                           end else begin
                              estado_d[i]   = ESPERA;
                              cuenta_d[i]   = cuenta_q[i] - UNO;
                           end
                        end
                     end
                     REPITE: begin
                        if (botonesLimpios[i]) begin
                           estado_d[i] = REPITE;
                           if (cuenta_q[i] == '0) begin
                              impulsos_d[i] = 1'b1;
                              cuenta_d[i]   = CARGA_PERIODO;
                           end else begin
                              cuenta_d[i]   = cuenta_q[i] - UNO;
                           end
                        end
                     end
                     default: estado_d[i] = REPOSO;
                  endcase
               end
               default: impulsos_d[i] = 1'b0;
            endcase
         end
         repitiendo_d[i] = (estado_d[i] == REPITE);
      end
   end

   // The counter advances together with the impulses it counts, so the
   // cycle that shows an impulse already shows it included in the total.
   always_comb begin
      popcount = '0;
      for (int i = 0; i < N_CANALES; i++) begin
         popcount = popcount + ANCHO_POP'(impulsos_d[i]);
      end
      suma = ANCHO_SUMA'(numImpulsos_q) + ANCHO_SUMA'(popcount);
      if (suma > TOPE) begin
         numImpulsos_d = '1;
      end else begin
         numImpulsos_d = ANCHO_CUENTA'(suma);
      end
   end

   // previo resets to all ones so a button held through reset is not a press.
   always_ff @(posedge clock1k) begin
      if (reset) begin
         previo_q      <= '1;
         impulsos_q    <= '0;
         repitiendo_q  <= '0;
         numImpulsos_q <= '0;
         for (int i = 0; i < N_CANALES; i++) begin
            estado_q[i] <= REPOSO;
            cuenta_q[i] <= '0;
         end
      end else begin
         previo_q      <= botonesLimpios;
         impulsos_q    <= impulsos_d;
         repitiendo_q  <= repitiendo_d;
         numImpulsos_q <= numImpulsos_d;
         for (int i = 0; i < N_CANALES; i++) begin
            estado_q[i] <= estado_d[i];
            cuenta_q[i] <= cuenta_d[i];
         end
      end
   end

   assign impulsos    = impulsos_q;
   assign repitiendo  = repitiendo_q;
   assign numImpulsos = numImpulsos_q;

endmodule

// File: tb/tb_impulsos_multicanal.sv
// Scoreboard bench for impulsos_multicanal: stimulus queues the expected impulse
// (edge number, value, running count, repeat flags); a monitor pops on each impulse.
module tb_impulsos_multicanal;

   localparam int N = 4;
   localparam int R = 3;
   localparam int P = 2;
   localparam int A = 3;

   logic         clock1k = 1'b0;
   logic         reset;
   logic [N-1:0] botones;
   logic [1:0]   modo;
   logic         habilitar;
   logic [N-1:0] impulsos;
   logic [A-1:0] numImpulsos;
   logic [N-1:0] repitiendo;

   int nEdge       = 0;
   int nCompared   = 0;
   int nMismatched = 0;
   int expNum      = 0;
   int t;

   typedef struct {
      int           edgeNum;
      logic [N-1:0] imp;
      logic [A-1:0] num;
      logic [N-1:0] rep;
   } expect_t;

   expect_t sb[$];

   impulsos_multicanal #(
      .N_CANALES   (N),
      .RETARDO_REP (R),
      .PERIODO_REP (P),
      .ANCHO_CUENTA(A)
   ) dut (
      .clock1k       (clock1k),
      .reset         (reset),
      .botonesLimpios(botones),
      .modo          (modo),
      .habilitar     (habilitar),
      .impulsos      (impulsos),
      .numImpulsos   (numImpulsos),
      .repitiendo    (repitiendo)
   );

   // Free-running clock and a count of rising edges used to time expectations.
   always #5 clock1k = ~clock1k;

   always @(posedge clock1k) nEdge = nEdge + 1;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock1k);
         #1;
      end
   endtask

   task automatic compareVal(input string name, input logic [31:0] act, input logic [31:0] req);
      nCompared = nCompared + 1;
      if (act !== req) begin
         nMismatched = nMismatched + 1;
         $display("[TB] FAIL %s actual=%0h required=%0h (edge %0d)", name, act, req, nEdge);
      end
   endtask

   task automatic checkOutput(input string name, input logic [N-1:0] imp,
                              input logic [A-1:0] num, input logic [N-1:0] rep);
      compareVal({name, "_imp"}, 32'(impulsos), 32'(imp));
      compareVal({name, "_num"}, 32'(numImpulsos), 32'(num));
      compareVal({name, "_rep"}, 32'(repitiendo), 32'(rep));
   endtask

   // Expected running count is a small saturating model kept by the bench.
   task automatic pushExp(input int e, input logic [N-1:0] imp, input logic [N-1:0] rep);
      expect_t r;
      int      s;
      s         = expNum + $countones(imp);
      expNum    = (s > 7) ? 7 : s;
      r.edgeNum = e;
      r.imp     = imp;
      r.num     = A'(expNum);
      r.rep     = rep;
      sb.push_back(r);
   endtask

   task automatic applyStimulus(input logic [N-1:0] btn, input logic [1:0] m,
                                input logic hab, input int ciclos);
      botones   = btn;
      modo      = m;
      habilitar = hab;
      tick(ciclos);
   endtask

   task automatic applyReset();
      reset     = 1'b1;
      botones   = '0;
      modo      = 2'b00;
      habilitar = 1'b1;
      tick(1);
      reset     = 1'b0;
      expNum    = 0;
      checkOutput("reset_state", 4'b0000, 3'd0, 4'b0000);
      tick(1);
   endtask

   // Monitor: every cycle that carries an impulse must match the head of the queue.
   always @(negedge clock1k) begin
      expect_t r;
      if (impulsos != 4'b0000) begin
         if (sb.size() == 0) begin
            nCompared   = nCompared + 1;
            nMismatched = nMismatched + 1;
            $display("[TB] FAIL sb_unexpected actual=%b required=none (edge %0d)", impulsos, nEdge);
         end else begin
            r = sb.pop_front();
            compareVal("sb_edge", 32'(nEdge), 32'(r.edgeNum));
            compareVal("sb_imp", 32'(impulsos), 32'(r.imp));
            compareVal("sb_num", 32'(numImpulsos), 32'(r.num));
            compareVal("sb_rep", 32'(repitiendo), 32'(r.rep));
         end
      end
   end

   initial begin
      reset     = 1'b1;
      botones   = '0;
      modo      = 2'b00;
      habilitar = 1'b1;

      // Rising-edge mode on channel 0, release gives nothing.
      applyReset();
      pushExp(nEdge + 1, 4'b0001, 4'b0000);
      applyStimulus(4'b0001, 2'b01, 1'b1, 3);
      applyStimulus(4'b0000, 2'b01, 1'b1, 2);

      // Off mode: press and release produce nothing.
      applyStimulus(4'b0001, 2'b00, 1'b1, 2);
      applyStimulus(4'b0000, 2'b00, 1'b1, 2);
      checkOutput("off_mode", 4'b0000, 3'd1, 4'b0000);

      // Falling-edge mode on channel 2.
      applyReset();
      applyStimulus(4'b0100, 2'b10, 1'b1, 5);
      pushExp(nEdge + 1, 4'b0100, 4'b0000);
      applyStimulus(4'b0000, 2'b10, 1'b1, 3);

      // Auto-repeat on channel 1 held for ten cycles.
      applyReset();
      t = nEdge + 1;
      pushExp(t,     4'b0010, 4'b0000);
      pushExp(t + 3, 4'b0010, 4'b0010);
      pushExp(t + 5, 4'b0010, 4'b0010);
      pushExp(t + 7, 4'b0010, 4'b0010);
      pushExp(t + 9, 4'b0010, 4'b0010);
      applyStimulus(4'b0010, 2'b11, 1'b1, 3);
      checkOutput("rep_espera", 4'b0000, 3'd1, 4'b0000);
      tick(1);
      checkOutput("rep_first", 4'b0010, 3'd2, 4'b0010);
      tick(6);
      applyStimulus(4'b0000, 2'b11, 1'b1, 1);
      checkOutput("rep_release", 4'b0000, 3'd5, 4'b0000);
      tick(4);

      // All channels together twice: count saturates at 7 and stays there.
      applyReset();
      pushExp(nEdge + 1, 4'b1111, 4'b0000);
      applyStimulus(4'b1111, 2'b01, 1'b1, 2);
      applyStimulus(4'b0000, 2'b01, 1'b1, 2);
      pushExp(nEdge + 1, 4'b1111, 4'b0000);
      applyStimulus(4'b1111, 2'b01, 1'b1, 1);
      checkOutput("sat_all", 4'b1111, 3'd7, 4'b0000);
      applyStimulus(4'b0000, 2'b01, 1'b1, 1);
      pushExp(nEdge + 1, 4'b0001, 4'b0000);
      applyStimulus(4'b0001, 2'b01, 1'b1, 1);
      checkOutput("sat_hold", 4'b0001, 3'd7, 4'b0000);
      applyStimulus(4'b0000, 2'b01, 1'b1, 2);

      // Reset in the middle of auto-repeat on channel 3.
      applyReset();
      t = nEdge + 1;
      pushExp(t,     4'b1000, 4'b0000);
      pushExp(t + 3, 4'b1000, 4'b1000);
      applyStimulus(4'b1000, 2'b11, 1'b1, 5);
      reset = 1'b1;
      tick(1);
      reset  = 1'b0;
      expNum = 0;
      checkOutput("mid_reset", 4'b0000, 3'd0, 4'b0000);
      tick(5);
      applyStimulus(4'b0000, 2'b11, 1'b1, 2);
      pushExp(nEdge + 1, 4'b1000, 4'b0000);
      applyStimulus(4'b1000, 2'b11, 1'b1, 2);
      applyStimulus(4'b0000, 2'b11, 1'b1, 2);

      // Disable while repeating on channel 2, re-enable while still held.
      applyReset();
      t = nEdge + 1;
      pushExp(t,     4'b0100, 4'b0000);
      pushExp(t + 3, 4'b0100, 4'b0100);
      applyStimulus(4'b0100, 2'b11, 1'b1, 4);
      applyStimulus(4'b0100, 2'b11, 1'b0, 1);
      checkOutput("disable", 4'b0000, 3'd2, 4'b0000);
      tick(3);
      applyStimulus(4'b0100, 2'b11, 1'b1, 4);
      checkOutput("reenable_held", 4'b0000, 3'd2, 4'b0000);
      applyStimulus(4'b0000, 2'b11, 1'b1, 2);
      pushExp(nEdge + 1, 4'b0100, 4'b0000);
      applyStimulus(4'b0100, 2'b11, 1'b1, 2);
      applyStimulus(4'b0000, 2'b00, 1'b1, 2);

      // Buttons low after reset in falling mode: every channel sees a release.
      reset     = 1'b1;
      modo      = 2'b10;
      botones   = '0;
      habilitar = 1'b1;
      tick(1);
      reset  = 1'b0;
      expNum = 0;
      pushExp(nEdge + 1, 4'b1111, 4'b0000);
      tick(1);
      checkOutput("fall_after_reset", 4'b1111, 3'd4, 4'b0000);
      tick(3);

      compareVal("sb_empty", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
